// File: rtl/gpa_fhdo_spi_master.sv
// SPI serializer for the GPA-FHDO gradient board: 24-bit frames out on MOSI,
// 24-bit readback captured on MISO, programmable SCLK half-period.
module gpa_fhdo_spi_master #(
  parameter int FRAME_BITS = 24,
  parameter int DIV_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIV_W-1:0]      spi_div_i,
  input  logic [FRAME_BITS-1:0] data_i,
  input  logic                  valid_i,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [FRAME_BITS-1:0] rdata_o,
  output logic                  rdata_valid_o,
  output logic                  spi_clk_o,
  output logic                  spi_csn_o,
  output logic                  spi_sdo_o,
  input  logic                  spi_sdi_i
);

  localparam int BW = $clog2(FRAME_BITS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]            state;
  logic [DIV_W-1:0]      div_q;
  logic [DIV_W-1:0]      cnt;
  logic [BW-1:0]         bit_q;
  logic [FRAME_BITS-1:0] tx_q;
  logic [FRAME_BITS-1:0] rx_q;
  logic                  tick;
  logic                  last_bit;
  logic                  accept;

  // cnt runs 0..div_q, so H = div_q+1 never needs an extra counter bit
  assign tick     = (cnt == div_q);
  assign last_bit = (bit_q == BW'(FRAME_BITS - 1));
  assign accept   = valid_i &&
                    ((state == S_IDLE) || ((state == S_GAP) && tick));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      div_q         <= '0;
      cnt           <= '0;
      bit_q         <= '0;
      tx_q          <= '0;
      rx_q          <= '0;
      busy_o        <= 1'b0;
      err_o         <= 1'b0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      spi_clk_o     <= 1'b0;
      spi_csn_o     <= 1'b1;
      spi_sdo_o     <= 1'b0;
    end else begin
      rdata_valid_o <= 1'b0;
      err_o         <= valid_i & busy_o & ~accept;
      cnt           <= (tick || state == S_IDLE) ? '0 : cnt + 1'b1;
      unique case (state)
        S_IDLE: begin
        end
        S_SETUP: begin
          if (tick) begin
            state     <= S_SHIFT;
            spi_clk_o <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (tick) begin
            if (spi_clk_o) begin
              // falling edge: capture MISO and present the next MOSI bit
              spi_clk_o <= 1'b0;
              rx_q      <= {rx_q[FRAME_BITS-2:0], spi_sdi_i};
              tx_q      <= tx_q << 1;
              spi_sdo_o <= last_bit ? 1'b0 : tx_q[FRAME_BITS-2];
            end else if (last_bit) begin
              state <= S_HOLD;
            end else begin
              spi_clk_o <= 1'b1;
              bit_q     <= bit_q + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (tick) begin
            state     <= S_GAP;
            spi_csn_o <= 1'b1;
          end
        end
        S_GAP: begin
          if (tick) begin
            state         <= S_IDLE;
            busy_o        <= 1'b0;
            rdata_o       <= rx_q;
            rdata_valid_o <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      // accept last so a back-to-back request overrides the GAP exit
      if (accept) begin
        state     <= S_SETUP;
        busy_o    <= 1'b1;
        spi_csn_o <= 1'b0;
        spi_clk_o <= 1'b0;
        spi_sdo_o <= data_i[FRAME_BITS-1];
        tx_q      <= data_i;
        div_q     <= spi_div_i;
        bit_q     <= '0;
        cnt       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gpa_fhdo_spi_master.sv
// Self-checking bench for gpa_fhdo_spi_master: frame timing, MOSI/MISO
// content, back-to-back requests, mid-frame reset and a tiny DAC model.
module tb_gpa_fhdo_spi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  spi_div_i = '0;
  logic [23:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        busy_o, err_o, rdata_valid_o;
  logic        spi_clk_o, spi_csn_o, spi_sdo_o, spi_sdi_i;
  logic [23:0] rdata_o;
  logic        loop_en = 1'b1;
  logic        sdi_drv = 1'b0;
  int          tests = 0;
  int          fails = 0;

  assign spi_sdi_i = loop_en ? spi_sdo_o : sdi_drv;

  always #5 clk = ~clk;

  gpa_fhdo_spi_master #(.FRAME_BITS(24), .DIV_W(6)) dut (
    .clk(clk), .rst(rst), .spi_div_i(spi_div_i), .data_i(data_i),
    .valid_i(valid_i), .busy_o(busy_o), .err_o(err_o), .rdata_o(rdata_o),
    .rdata_valid_o(rdata_valid_o), .spi_clk_o(spi_clk_o),
    .spi_csn_o(spi_csn_o), .spi_sdo_o(spi_sdo_o), .spi_sdi_i(spi_sdi_i)
  );

  // minimal DAC80504 model: command 0x08 loads voutx on csn rise
  logic [23:0] brd_sh = '0;
  logic [15:0] voutx = '0;
  logic        brd_pc = 1'b0, brd_pcs = 1'b1, brd_ps = 1'b0;
  always @(negedge clk) begin
    if (!spi_csn_o && brd_pc && !spi_clk_o) brd_sh <= {brd_sh[22:0], brd_ps};
    if (spi_csn_o && !brd_pcs && brd_sh[23:16] == 8'h08) voutx <= brd_sh[15:0];
    brd_pc  <= spi_clk_o;
    brd_pcs <= spi_csn_o;
    brd_ps  <= spi_sdo_o;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // mode 0 loopback, 1 MISO held high, 2 random MISO per cycle
  task automatic run_frame(input string tag, input logic [23:0] d, input int dv,
                           input int mode, input logic [23:0] exp_rd,
                           input int exp_busy, input int exp_csn,
                           input int chg_at, input int chg_div);
    int h = dv + 1;
    int busy_n = 0, csn_n = 0, err_n = 0, rises = 0, rv_n = 0;
    int hi_bad = 0, lo_bad = 0, run = 0, setup = 0, trail = -1, cyc = 0;
    logic [23:0] mosi = '0, rx_exp = '0, got = '0;
    logic pclk = 1'b0, psdo = 1'b0, psdi = 1'b0, done = 1'b0;
    @(negedge clk);
    loop_en   = (mode == 0);
    sdi_drv   = (mode == 1);
    psdi      = sdi_drv;
    data_i    = d;
    spi_div_i = 6'(dv);
    valid_i   = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    while (!done && cyc < exp_busy + 40) begin
      if (cyc == chg_at) begin
        spi_div_i = 6'(chg_div);
        data_i    = ~d;
      end
      busy_n += int'(busy_o);
      csn_n  += int'(!spi_csn_o);
      err_n  += int'(err_o);
      if (!spi_csn_o) begin
        if (spi_clk_o != pclk) begin
          if (pclk) begin
            hi_bad += int'(run != h);
            mosi   = {mosi[22:0], psdo};
            rx_exp = {rx_exp[22:0], psdi};
          end else if (rises == 0) setup = run;
          else lo_bad += int'(run != h);
          if (spi_clk_o) rises++;
          run = 1;
        end else run++;
      end else if (trail < 0 && rises > 0) trail = run;
      if (rdata_valid_o) begin
        rv_n++;
        got  = rdata_o;
        done = 1'b1;
        chk({tag, "_busy_low_at_rvalid"}, busy_o, 1'b0);
      end
      pclk = spi_clk_o;
      psdo = spi_sdo_o;
      if (mode == 2) sdi_drv = 1'($urandom);
      psdi = sdi_drv;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_completed"}, done, 1'b1);
    chk({tag, "_rvalid_single"}, rdata_valid_o, 1'b0);
    chk({tag, "_busy_cycles"}, busy_n, exp_busy);
    chk({tag, "_csn_cycles"}, csn_n, exp_csn);
    chk({tag, "_sclk_rises"}, rises, 24);
    chk({tag, "_high_phase_bad"}, hi_bad, 0);
    chk({tag, "_low_phase_bad"}, lo_bad, 0);
    chk({tag, "_setup_len"}, setup, h);
    chk({tag, "_trail_low_len"}, trail, 2 * h);
    chk({tag, "_mosi"}, mosi, d);
    chk({tag, "_rdata"}, got, (mode == 2) ? rx_exp : exp_rd);
    chk({tag, "_rvalid_cnt"}, rv_n, 1);
    chk({tag, "_err_cnt"}, err_n, 0);
  endtask

  typedef struct {
    logic [23:0] data;
    int          div;
    int          mode;
    logic [23:0] exp_rd;
    int          exp_busy;
    int          exp_csn;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int bad, errs, csnh, rvs, rises, prev;
    logic [23:0] d;
    int dv, md;

    tbl[0] = '{24'h03ABCD, 0, 0, 24'h03ABCD, 51, 50};
    tbl[1] = '{24'h100000, 4, 1, 24'hFFFFFF, 255, 250};
    tbl[2] = '{24'h000001, 0, 1, 24'hFFFFFF, 51, 50};
    tbl[3] = '{24'hC3C3C3, 63, 0, 24'hC3C3C3, 3264, 3200};
    tbl[4] = '{24'h800000, 2, 0, 24'h800000, 153, 150};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_rdata", rdata_o, 24'h0);
    chk("rst_rvalid", rdata_valid_o, 1'b0);
    chk("rst_sclk", spi_clk_o, 1'b0);
    chk("rst_csn", spi_csn_o, 1'b1);
    chk("rst_sdo", spi_sdo_o, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_frame($sformatf("tbl%0d", i), tbl[i].data, tbl[i].div, tbl[i].mode,
                tbl[i].exp_rd, tbl[i].exp_busy, tbl[i].exp_csn, -1, 0);

    run_frame("board", 24'h088000, 1, 0, 24'h088000, 102, 100, -1, 0);
    repeat (2) @(negedge clk);
    chk("board_voutx", voutx, 16'h8000);

    run_frame("divchg", 24'h5A0F33, 1, 0, 24'h5A0F33, 102, 100, 10, 7);
    run_frame("divnext", 24'h2468AC, 7, 0, 24'h2468AC, 408, 400, -1, 0);

    // valid held high: three frames back to back at H=1
    @(negedge clk);
    loop_en = 1'b1;
    data_i = 24'h5A5A5A;
    spi_div_i = 6'd0;
    valid_i = 1'b1;
    bad = 0; errs = 0; csnh = 0; rvs = 0;
    for (int s = 1; s <= 153; s++) begin
      @(negedge clk);
      bad  += int'(!busy_o);
      bad  += int'(spi_csn_o != (s % 51 == 0));
      errs += int'(err_o);
      csnh += int'(spi_csn_o);
      if (rdata_valid_o) begin
        rvs++;
        bad += int'(rdata_o != 24'h5A5A5A);
      end
    end
    valid_i = 1'b0;
    chk("b2b_pattern_bad", bad, 0);
    chk("b2b_err_pulses", errs, 150);
    chk("b2b_csn_high", csnh, 3);
    chk("b2b_rvalid", rvs, 2);
    @(negedge clk);
    chk("b2b_last_rvalid", rdata_valid_o, 1'b1);
    chk("b2b_last_rdata", rdata_o, 24'h5A5A5A);
    chk("b2b_idle", busy_o, 1'b0);

    // dropped request, then reset at the 10th bit
    @(negedge clk);
    data_i = 24'h5C3F0E;
    spi_div_i = 6'd2;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (4) @(negedge clk);
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    chk("drop_err_pulse", err_o, 1'b1);
    @(negedge clk);
    chk("drop_err_clear", err_o, 1'b0);
    rises = 0; prev = 0;
    for (int c = 0; c < 1000 && rises < 10; c++) begin
      @(negedge clk);
      if (spi_clk_o && prev == 0) rises++;
      prev = int'(spi_clk_o);
    end
    chk("rst_reach_bit10", rises, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_csn", spi_csn_o, 1'b1);
    chk("midrst_sclk", spi_clk_o, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_rvalid", rdata_valid_o, 1'b0);
    chk("midrst_rdata", rdata_o, 24'h0);
    rvs = 0;
    repeat (100) begin
      @(negedge clk);
      rvs += int'(rdata_valid_o) + int'(!spi_csn_o);
    end
    chk("midrst_quiet", rvs, 0);
    run_frame("afterrst", 24'hA5A5A5, 0, 0, 24'hA5A5A5, 51, 50, -1, 0);

    for (int i = 0; i < 8; i++) begin
      d  = 24'($urandom);
      dv = int'($urandom_range(0, 5));
      md = int'($urandom_range(0, 2));
      run_frame($sformatf("rnd%0d", i), d, dv, md,
                (md == 1) ? 24'hFFFFFF : d,
                (3 + 2 * 24) * (dv + 1), (2 + 2 * 24) * (dv + 1), -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
